// File: rtl/rns_dot_pkg.sv
// Shared types and modular-arithmetic helpers for the RNS dot-product accumulator.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rns_dot_pkg;

    // Helpers work on a fixed wide word; callers cast to/from their own width.
    localparam int MAX_W = 32;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    // Single conditional subtract; callers guarantee x < 2*m.
    function automatic logic [MAX_W-1:0] mod_norm(input logic [MAX_W-1:0] x,
                                                  input logic [MAX_W-1:0] m);
        return (x >= m) ? x - m : x;
    endfunction

    // Operands are already reduced (< m), so one subtract brings the sum back into range.
    function automatic logic [MAX_W-1:0] mod_add(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input logic [MAX_W-1:0] m);
        logic [MAX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m})
            s = s - {1'b0, m};
        return s[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/rns_dot_accum_if.sv
// Term/product input and finished-sum output bundle of the RNS dot-product accumulator.
// Latency: n/a (wires only).
// Backpressure: in_ready is credit-based; out_valid/out_ready is a plain handshake.
// master = upstream lane driver plus downstream consumer; slave = rns_dot_accum.
interface rns_dot_accum_if #(
    parameter int DATA_WIDTH = 18
);
    logic                  in_valid;
    logic                  in_first;
    logic                  in_last;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] prod;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [7:0]            out_terms;
    logic                  err_range;
    logic                  err_seq;

    modport master (
        output in_valid, in_first, in_last, prod, out_ready,
        input  in_ready, out_valid, out_data, out_terms, err_range, err_seq
    );

    modport slave (
        input  in_valid, in_first, in_last, prod, out_ready,
        output in_ready, out_valid, out_data, out_terms, err_range, err_seq
    );
endinterface

// File: rtl/rns_dot_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// Latency: a push is visible on head the cycle after it is written.
// Backpressure: none internally; the writer must never push a full queue without a pop.
// Ports: clk/reset, push/push_data, pop, head (0 when empty), count, empty.
module rns_dot_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push-at-full is legal then.
    assign do_push = push && (!full || do_pop);
    // Head reads as zero while empty so the output is defined out of reset.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            assert (!(push && full && !pop));
    end

endmodule

// File: rtl/rns_dot_accum.sv
// Sums each framed vector of lane products modulo MODULUS and queues finished sums.
// Latency: last term accepted at cycle c -> out_valid at c+MULT_LATENCY+1 (empty queue).
// Backpressure: in_ready withheld unless queue + in-flight lasts leave a free entry.
// Ports: clk, reset (sync, active-high), bus (rns_dot_accum_if.slave).
// Option: RNS_DOT_ACCUM_CNT_EN adds a saturating 8-bit per-vector term count on out_terms.
module rns_dot_accum
    import rns_dot_pkg::*;
#(
    parameter int MODULUS      = 177147,
    parameter int DATA_WIDTH   = 18,
    parameter int MULT_LATENCY = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    rns_dot_accum_if.slave  bus
);
`ifdef RNS_DOT_ACCUM_CNT_EN
    localparam int QW = DATA_WIDTH + 8;
`else
    localparam int QW = DATA_WIDTH;
`endif
    localparam logic [DATA_WIDTH-1:0] MOD_W = DATA_WIDTH'(MODULUS);

    tag_t                    pipe [MULT_LATENCY];
    tag_t                    tag_out;
    state_e                  state;
    logic [DATA_WIDTH-1:0]   acc;
    logic [DATA_WIDTH-1:0]   t;
    logic [DATA_WIDTH-1:0]   s;
    logic [DATA_WIDTH-1:0]   push_val;
    logic                    start;
    logic                    push;
    logic                    accept;
    logic                    err_range_q;
    logic                    err_seq_q;
    int                      lasts_in_pipe;
    logic [QW-1:0]           push_data;
    logic [QW-1:0]           head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                    fifo_empty;

    // Every last tag in flight will push exactly once, so it already owns a queue slot.
    assign bus.in_ready = !reset && ((int'(fifo_count) + lasts_in_pipe) < FIFO_DEPTH);
    assign accept       = bus.in_valid && bus.in_ready;
    assign tag_out      = pipe[MULT_LATENCY-1];

    always_comb begin
        lasts_in_pipe = 0;
        for (int i = 0; i < MULT_LATENCY; i++)
            if (pipe[i].valid && pipe[i].last)
                lasts_in_pipe = lasts_in_pipe + 1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MULT_LATENCY; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= tag_t'{valid: accept, first: accept && bus.in_first,
                              last: accept && bus.in_last};
            for (int i = 1; i < MULT_LATENCY; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    always_comb begin
        t = DATA_WIDTH'(mod_norm(MAX_W'(bus.prod), MAX_W'(MOD_W)));
        s = DATA_WIDTH'(mod_add(MAX_W'(acc), MAX_W'(t), MAX_W'(MOD_W)));
        // With no open vector every term restarts the sum, framed or not.
        start    = (state == IDLE) || tag_out.first;
        push_val = start ? t : s;
        push     = tag_out.valid && tag_out.last;
    end

`ifdef RNS_DOT_ACCUM_CNT_EN
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    always_comb begin
        cnt_nxt = start ? 8'd1 : ((cnt == 8'hFF) ? cnt : cnt + 8'd1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (tag_out.valid)
            cnt <= cnt_nxt;
    end

    assign push_data     = {cnt_nxt, push_val};
    assign bus.out_terms = head[QW-1 -: 8];
`else
    assign push_data     = push_val;
    assign bus.out_terms = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            err_range_q <= 1'b0;
            err_seq_q   <= 1'b0;
        end else if (tag_out.valid) begin
            acc   <= push_val;
            state <= tag_out.last ? IDLE : ACC;
            if (bus.prod >= MOD_W)
                err_range_q <= 1'b1;
            if ((state == IDLE && !tag_out.first) || (state == ACC && tag_out.first))
                err_seq_q <= 1'b1;
        end
    end

    rns_dot_fifo #(
        .WIDTH (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (bus.out_ready),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = head[DATA_WIDTH-1:0];
    assign bus.err_range = err_range_q;
    assign bus.err_seq   = err_seq_q;

endmodule
